sort_pipe: RTL and testbench
============================

# sort_pipe

Parametrised, fully pipelined sorter for the median filter datapath. It accepts one packed vector of NUM_ELEM unsigned samples per cycle and returns the vector sorted in ascending order, plus the min, median and max elements. Ordering uses an odd-even transposition network of registered compare-exchange stages, with valid/ready flow control on both sides. It sits between the window buffer and the filter output stage, replacing the combinational compare-exchange mesh.

## Interface

- DATA_WIDTH, 8, bits per sample; must be ≥ 1.
- NUM_ELEM, 9, samples per vector (9 for a 3x3 window); must be ≥ 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_ELEM*DATA_WIDTH  packed input vector; element i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  NUM_ELEM*DATA_WIDTH  sorted vector, same packing; element 0 is the smallest.
- out_min  out  DATA_WIDTH  element 0 of out_data.
- out_median  out  DATA_WIDTH  element NUM_ELEM/2 (integer division) of out_data.
- out_max  out  DATA_WIDTH  element NUM_ELEM-1 of out_data.
- out_valid  out  1  out_* holds a sorted result.
- out_ready  in  1  downstream accepts the result this cycle.

## Operation

- Pipeline has NUM_ELEM register stages, S0..S(NUM_ELEM-1). Each stage holds a data vector and one valid bit.
- Stage k compare-exchanges element pairs (j, j+1):
  - even k: j = 0, 2, 4, …
  - odd k: j = 1, 3, 5, …
  - Elements not in any pair pass through unchanged.
- Compare-exchange: the lower index receives the smaller value and the higher index the larger. On equality no swap occurs (strict greater-than test), so tied elements keep their relative order.
- S0 operates on in_data. Stage k>0 operates on the output of stage k-1. out_data is the output of the last stage.
- Global stall: `advance = !(out_valid && !out_ready)`.
  - When advance is 1, every stage loads from its predecessor, and S0 loads in_data with valid = in_valid.
  - When advance is 0, every stage holds its data and valid bit.
- in_ready = advance. A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
- Bubbles (valid = 0) propagate normally. Data registers of bubble stages are don't-care but must not alter the valid bits.
- Comparison is unsigned by default; see Configuration.
- No internal state beyond the stage registers. The block has no FSM: flow control is the single advance term.

## Timing

- Reset: all valid bits are 0 and all data registers are 0. After reset, out_valid = 0, out_data = 0, out_min/out_median/out_max = 0, and in_ready = 1.
- Reset mid-stream discards every in-flight vector. No result from before reset ever appears at the output.
- Latency: a vector accepted at edge t is presented at the output (out_valid = 1) after edge t+NUM_ELEM-1, i.e. NUM_ELEM register stages.
- Throughput: one vector per cycle while out_ready = 1.
- While stalled, out_* and out_valid are held stable and in_ready = 0. The producer must hold in_data and in_valid until accepted.
- in_ready depends combinationally on out_valid and out_ready only. There is no combinational path from in_valid or in_data to any output.
- Simultaneous transfer in and out with a full pipeline is allowed and loses nothing.
- out_min, out_median and out_max are combinational slices of the last-stage register, so they add no latency.

## Configuration

- SORT_SIGNED_EN defined: samples are compared as two's-complement signed DATA_WIDTH values. For DATA_WIDTH=8, 0x80 (−128) sorts smallest.
- SORT_SIGNED_EN undefined: unsigned comparison; 0x80 sorts above 0x7F.
- The macro has no effect on packing, latency or the handshake.

## Test plan

All scenarios use DATA_WIDTH=8 and NUM_ELEM=9.

1. **Reversed input.** Element i = 9−i (values 9..1), out_ready = 1.
   - Result appears 9 cycles after acceptance.
   - out_data elements 0..8 = 1..9; out_min = 1, out_median = 5, out_max = 9.
2. **Streaming.** 20 random vectors back to back, in_valid and out_ready held at 1.
   - After the first result, out_valid stays at 1 for 20 consecutive cycles.
   - Results arrive in input order and match the reference sort.
3. **Backpressure.** Fill the pipeline, then drop out_ready for 5 cycles.
   - in_ready = 0 and out_* stay stable for those 5 cycles.
   - After release, all vectors drain in order with none lost or duplicated.
4. **Ties and extremes.** Eight 0xFF elements and one 0x00 placed at element 4.
   - out_min = 0x00, out_median = 0xFF, out_max = 0xFF.
   - All-equal input 0x3C returns all 0x3C.
5. **Signed mode.** Inputs 0x80, 0x7F, 0x00 and six 0x01.
   - With SORT_SIGNED_EN: out_min = 0x80, out_max = 0x7F.
   - Without it: out_min = 0x00, out_max = 0x80.
6. **Reset mid-stream.** Pulse rst for one cycle with 3 vectors in flight.
   - From the next cycle onward, out_valid = 0, out_data = 0 and in_ready = 1.
   - No pre-reset vector ever appears at the output.

Source files
------------

// File: rtl/sort_pipe.sv
// Pipelined odd-even transposition sorter: NUM_ELEM registered compare-exchange stages, global stall.
// Define SORT_SIGNED_EN to compare samples as two's-complement signed values (default unsigned).
module sort_pipe_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEM   = 9,
  parameter int PHASE      = 0
) (
  input  logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] i_vec,
  output logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] o_vec
);
  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef SORT_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Strict greater-than keeps tied elements in place; unpaired edge elements pass through.
  always_comb begin
    o_vec = i_vec;
    for (int j = PHASE; j < NUM_ELEM - 1; j += 2) begin
      if (gt(i_vec[j], i_vec[j+1])) begin
        o_vec[j]   = i_vec[j+1];
        o_vec[j+1] = i_vec[j];
      end
    end
  end
endmodule

module sort_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEM   = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_ELEM*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_ELEM*DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0]          out_min,
  output logic [DATA_WIDTH-1:0]          out_median,
  output logic [DATA_WIDTH-1:0]          out_max,
  output logic                           out_valid,
  input  logic                           out_ready
);
  logic [NUM_ELEM-1:0][NUM_ELEM-1:0][DATA_WIDTH-1:0] r_data;
  logic [NUM_ELEM-1:0][NUM_ELEM-1:0][DATA_WIDTH-1:0] w_src;
  logic [NUM_ELEM-1:0][NUM_ELEM-1:0][DATA_WIDTH-1:0] w_cx;
  logic [NUM_ELEM-1:0]                               r_vld_pipe;
  logic                                              w_advance;

  assign w_src = {r_data[NUM_ELEM-2:0], in_data};

  for (genvar k = 0; k < NUM_ELEM; k++) begin : g_stage
    sort_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_ELEM   (NUM_ELEM),
      .PHASE      (k % 2)
    ) u_stage (
      .i_vec (w_src[k]),
      .o_vec (w_cx[k])
    );
  end

  assign w_advance = !(r_vld_pipe[NUM_ELEM-1] && !out_ready);

  // Bubble data is loaded like any other; only the valid pipe decides what is real.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_vld_pipe <= '0;
    end else if (w_advance) begin
      r_data     <= w_cx;
      r_vld_pipe <= {r_vld_pipe[NUM_ELEM-2:0], in_valid};
    end
  end

  assign in_ready   = w_advance;
  assign out_valid  = r_vld_pipe[NUM_ELEM-1];
  assign out_data   = r_data[NUM_ELEM-1];
  assign out_min    = r_data[NUM_ELEM-1][0];
  assign out_median = r_data[NUM_ELEM-1][NUM_ELEM/2];
  assign out_max    = r_data[NUM_ELEM-1][NUM_ELEM-1];
endmodule

// File: tb/tb_sort_pipe.sv
// Directed bench for sort_pipe (DATA_WIDTH=8, NUM_ELEM=9) with an in-order scoreboard on the output.
module tb_sort_pipe;
  localparam int DW = 8;
  localparam int NE = 9;
  localparam int VW = DW * NE;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [VW-1:0] in_data, out_data;
  logic [DW-1:0] out_min, out_median, out_max;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [VW-1:0] exp_q[$];

  always #5 clk = ~clk;

  sort_pipe #(.DATA_WIDTH(DW), .NUM_ELEM(NE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_min    (out_min),
    .out_median (out_median),
    .out_max    (out_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SORT_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Stable insertion sort as the reference.
  function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] v);
    logic [DW-1:0] e[NE];
    logic [DW-1:0] t;
    logic [VW-1:0] r;
    int j;
    for (int i = 0; i < NE; i++) e[i] = v[i*DW +: DW];
    for (int i = 1; i < NE; i++) begin
      t = e[i];
      j = i - 1;
      while (j >= 0 && gt(e[j], t)) begin
        e[j+1] = e[j];
        j--;
      end
      e[j+1] = t;
    end
    for (int i = 0; i < NE; i++) r[i*DW +: DW] = e[i];
    return r;
  endfunction

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] val);
    logic [VW-1:0] r;
    for (int i = 0; i < NE; i++) r[i*DW +: DW] = val;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("out_expected", VW'(exp_q.size() > 0), VW'(1));
        if (exp_q.size() > 0) begin
          chk("order", out_data, exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_sort(in_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [VW-1:0] v, input string tag);
    int lat;
    in_data  = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, VW'(lat), VW'(NE));
  endtask

  initial begin
    logic [VW-1:0] v, e, snap;
    logic [VW-1:0] sv[20];
    logic [39:0]   ov;
    int first, run, n0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", VW'(out_valid), VW'(0));
    chk("rst_data", out_data, '0);
    chk("rst_min", VW'(out_min), VW'(0));
    chk("rst_med", VW'(out_median), VW'(0));
    chk("rst_max", VW'(out_max), VW'(0));
    chk("rst_ready", VW'(in_ready), VW'(1));

    // Reversed input 9..1
    for (int i = 0; i < NE; i++) begin
      v[i*DW +: DW] = DW'(9 - i);
      e[i*DW +: DW] = DW'(i + 1);
    end
    run_one(v, "rev");
    chk("rev_data", out_data, e);
    chk("rev_min", VW'(out_min), VW'(1));
    chk("rev_med", VW'(out_median), VW'(5));
    chk("rev_max", VW'(out_max), VW'(9));
    step();
    chk("rev_bubble", VW'(out_valid), VW'(0));

    // Ties and extremes
    v = fill(8'hFF);
    v[4*DW +: DW] = 8'h00;
    e = fill(8'hFF);
    e[0 +: DW] = 8'h00;
    run_one(v, "ties");
    chk("ties_data", out_data, e);
    chk("ties_min", VW'(out_min), VW'(8'h00));
    chk("ties_med", VW'(out_median), VW'(8'hFF));
    chk("ties_max", VW'(out_max), VW'(8'hFF));
    run_one(fill(8'h3C), "eq");
    chk("eq_data", out_data, fill(8'h3C));

    // Signedness
    v = fill(8'h01);
    v[0*DW +: DW] = 8'h80;
    v[1*DW +: DW] = 8'h7F;
    v[2*DW +: DW] = 8'h00;
    run_one(v, "sgn");
`ifdef SORT_SIGNED_EN
    chk("sgn_min", VW'(out_min), VW'(8'h80));
    chk("sgn_med", VW'(out_median), VW'(8'h01));
    chk("sgn_max", VW'(out_max), VW'(8'h7F));
`else
    chk("sgn_min", VW'(out_min), VW'(8'h00));
    chk("sgn_med", VW'(out_median), VW'(8'h01));
    chk("sgn_max", VW'(out_max), VW'(8'h80));
`endif
    step();

    // Streaming 20 vectors back to back
    for (int n = 0; n < 20; n++)
      for (int i = 0; i < NE; i++) sv[n][i*DW +: DW] = DW'($urandom_range(0, 255));
    for (int c = 0; c < 40; c++) begin
      in_valid = (c < 20);
      if (c < 20) in_data = sv[c];
      step();
      ov[c] = out_valid;
    end
    in_valid = 1'b0;
    first = -1;
    run = 0;
    for (int c = 0; c < 40; c++)
      if (ov[c] && first < 0) first = c;
    if (first >= 0)
      for (int c = first; c < 40 && ov[c]; c++) run++;
    chk("stream_first", VW'(first), VW'(NE - 1));
    chk("stream_run", VW'(run), VW'(20));

    // Backpressure on a full pipeline
    n0 = n_out;
    for (int c = 0; c < NE; c++) begin
      in_valid = 1'b1;
      in_data  = sv[c];
      step();
    end
    chk("bp_full", VW'(out_valid), VW'(1));
    in_data   = sv[NE];
    out_ready = 1'b0;
    #1;
    snap = out_data;
    chk("bp_ready0", VW'(in_ready), VW'(0));
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_ready", VW'(in_ready), VW'(0));
      chk("bp_valid", VW'(out_valid), VW'(1));
      chk("bp_hold", out_data, snap);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 15; c++) step();
    chk("bp_count", VW'(n_out - n0), VW'(NE + 1));
    chk("bp_drained", VW'(exp_q.size()), VW'(0));

    // Reset with three vectors in flight
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = sv[c + 12];
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", VW'(out_valid), VW'(0));
    chk("mrst_data", out_data, '0);
    chk("mrst_ready", VW'(in_ready), VW'(1));
    for (int c = 0; c < 12; c++) begin
      step();
      chk("mrst_quiet", VW'(out_valid), VW'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
